seg7_scan_capture: RTL and testbench
====================================

// Module: seg7_scan_capture
// PURPOSE
//  Reverse path of the BCD->7-segment decoder: watches a multiplexed 7-segment display
//  bus (segment pattern + digit-select lines) and recovers the BCD value of every digit.
//  A pattern is accepted only after it has been stable for a set number of clock cycles.
//  Feeds the I/O register space so the CPU can read back what is shown on the display.
// PARAMETERS
//  NDIG           4   number of multiplexed digits (1..8)
//  STABLE_CYC     4   consecutive identical samples needed to accept a pattern (2..255)
//  SEG_ACTIVE_LOW 0   1: invert seg before decoding (common-anode display)
// PORTS
//  clk      in   1        rising-edge clock
//  reset    in   1        asynchronous, active-high reset
//  seg      in   8        segment bus {dp,g,f,e,d,c,b,a}; bit 7 (dp) ignored
//  an       in   NDIG     digit select, active-high, must be one-hot to capture
//  q_bcd    out  4*NDIG   recovered digits; digit i at [4i+3:4i]
//  q_valid  out  NDIG     bit i = 1: q_bcd digit i holds a valid decoded value
//  upd      out  1        1-cycle pulse: a valid digit was written this edge
//  err      out  1        1-cycle pulse: a stable but undecodable pattern was seen
// BEHAVIOUR
//  - Reset (async, any time): q_bcd=0, q_valid=0, upd=0, err=0, sample regs=0, run
//    counter=0. Reset mid-run discards the run; counting restarts after release.
//  - Effective pattern p = seg[6:0] (inverted if SEG_ACTIVE_LOW). Sampling every edge.
//  - Run: consecutive edges on which {p,an} is identical and an is one-hot. Any change
//    of p or an, or an zero / multi-hot, ends the run; counter returns to 0.
//  - Capture: on the edge completing the STABLE_CYC-th identical sample of a run
//    (run starting at edge t0 -> capture at edge t0+STABLE_CYC-1), exactly once per run.
//    Counter saturates; no further capture until the run ends and a new one completes.
//  - Decode table (p -> digit): 3F->0 06->1 5B->2 4F->3 66->4 6D->5 7D->6 07->7
//    7F->8 67->9. Any other p is invalid.
//  - Valid capture on digit i (i = index of set an bit): q_bcd digit i <= value,
//    q_valid[i] <= 1, upd=1 for that cycle only; other digits untouched.
//  - Invalid capture on digit i: q_valid[i] <= 0, q_bcd digit i keeps old value,
//    err=1 for that cycle only; upd=0.
//  - upd and err never both 1. Same value re-captured after a break -> upd pulses again.
//  - Run counter width: clog2(STABLE_CYC+1); no wrap (saturating).
// TESTING
//  1 Reset: assert reset mid-simulation with outputs nonzero -> all outputs 0 immediately.
//  2 an=0001, seg=0x3F held 10 cycles -> at 4th edge q_bcd[3:0]=0, q_valid=0001,
//    single upd pulse; no further upd for remaining 6 cycles.
//  3 an=0100, seg=0x67 held 3 cycles then seg=0x00 -> no capture; then 0x67 held 4
//    cycles -> q_bcd[11:8]=9, q_valid[2]=1, one upd.
//  4 digit1 holds 5 (seg=0x6D); then an=0010, seg=0x49 held 4 -> err pulse,
//    q_valid[1]=0, q_bcd[7:4] still 5, upd=0.
//  5 an=0011 or an=0000 with seg=0x06 held 20 cycles -> no upd/err, outputs unchanged;
//    seg=0xCF on an=1000 held 4 -> q_bcd[15:12]=3 (dp ignored).
//  6 an=0001, seg=0x07 for 2 cycles, reset pulse, release, hold 4 more -> capture
//    (digit0=7) only on 4th post-reset edge; SEG_ACTIVE_LOW=1 with seg=0xF9 -> digit 1.

Source files
------------

// File: rtl/seg7_scan_capture_if.sv
// Display-bus monitor interface: the observed segment/digit-select lines
// plus the recovered digit values and event pulses.
interface seg7_scan_capture_if #(
  parameter int unsigned NDIG = 4
);
  logic [7:0]        seg;
  logic [NDIG-1:0]   an;
  logic [4*NDIG-1:0] q_bcd;
  logic [NDIG-1:0]   q_valid;
  logic              upd;
  logic              err;

  // Display side: drives the bus, observes the recovered values.
  modport master (
    output seg, an,
    input  q_bcd, q_valid, upd, err
  );

  // Capture side: watches the bus, produces the recovered values.
  modport slave (
    input  seg, an,
    output q_bcd, q_valid, upd, err
  );
endinterface

// File: rtl/seg7_scan_capture.sv
// Recovers BCD digits from a multiplexed 7-segment display bus. A pattern on a
// one-hot digit select is accepted once it has been seen on STABLE_CYC
// consecutive edges; each stable run is captured exactly once.
module seg7_scan_capture #(
  parameter int unsigned NDIG           = 4,
  parameter int unsigned STABLE_CYC     = 4,
  parameter bit          SEG_ACTIVE_LOW = 1'b0
) (
  input logic               clk,
  input logic               reset,
  seg7_scan_capture_if.slave bus
);

  localparam int unsigned       CW       = $clog2(STABLE_CYC + 1);
  localparam logic [CW-1:0]     CNT_MAX  = CW'(STABLE_CYC);
  localparam logic [CW-1:0]     CNT_LAST = CW'(STABLE_CYC - 1);

  logic [6:0]        p;
  logic              onehot;
  logic              same;
  logic              capture;
  logic [3:0]        dig_val;
  logic              dig_ok;
  logic              unused_dp;

  logic [6:0]        p_q, p_d;
  logic [NDIG-1:0]   an_q, an_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [4*NDIG-1:0] q_bcd_q, q_bcd_d;
  logic [NDIG-1:0]   q_valid_q, q_valid_d;
  logic              upd_q, upd_d;
  logic              err_q, err_d;

  // Map the effective segment pattern to a decimal digit.
  always_comb begin
    dig_val = '0;
    dig_ok  = 1'b1;
    case (p)
      7'h3F: dig_val = 4'd0;
      7'h06: dig_val = 4'd1;
      7'h5B: dig_val = 4'd2;
      7'h4F: dig_val = 4'd3;
      7'h66: dig_val = 4'd4;
      7'h6D: dig_val = 4'd5;
      7'h7D: dig_val = 4'd6;
      7'h07: dig_val = 4'd7;
      7'h7F: dig_val = 4'd8;
      7'h67: dig_val = 4'd9;
      default: begin
        dig_val = '0;
        dig_ok  = 1'b0;
      end
    endcase
  end

  // Run tracking and capture of the selected digit.
  always_comb begin
    unused_dp = bus.seg[7];
    p         = bus.seg[6:0] ^ {7{SEG_ACTIVE_LOW}};
    onehot    = (bus.an != '0) && ((bus.an & (bus.an - NDIG'(1))) == '0);
    same      = onehot && (p == p_q) && (bus.an == an_q);

    p_d  = p;
    an_d = bus.an;

    // The counter holds the length of the current run including this edge;
    // a break starts a new run at 1 when the new sample is itself eligible.
    if (!onehot)                cnt_d = '0;
    else if (!same)             cnt_d = CW'(1);
    else if (cnt_q != CNT_MAX)  cnt_d = cnt_q + CW'(1);
    else                        cnt_d = cnt_q;

    capture = same && (cnt_q == CNT_LAST);

    q_bcd_d   = q_bcd_q;
    q_valid_d = q_valid_q;
    for (int unsigned i = 0; i < NDIG; i++) begin
      if (capture && bus.an[i]) begin
        if (dig_ok) q_bcd_d[4*i +: 4] = dig_val;
        q_valid_d[i] = dig_ok;
      end
    end

    upd_d = capture && dig_ok;
    err_d = capture && !dig_ok;
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_q       <= '0;
      an_q      <= '0;
      cnt_q     <= '0;
      q_bcd_q   <= '0;
      q_valid_q <= '0;
      upd_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      p_q       <= p_d;
      an_q      <= an_d;
      cnt_q     <= cnt_d;
      q_bcd_q   <= q_bcd_d;
      q_valid_q <= q_valid_d;
      upd_q     <= upd_d;
      err_q     <= err_d;
    end
  end

  assign bus.q_bcd   = q_bcd_q;
  assign bus.q_valid = q_valid_q;
  assign bus.upd     = upd_q;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Directed bench for seg7_scan_capture: common-cathode instance plus a
// common-anode instance sharing clock and reset.
module tb_seg7_scan_capture;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;
  int   upd_cnt;
  int   err_cnt;
  int   upd_cnt_n;

  seg7_scan_capture_if #(.NDIG(4)) bus   ();
  seg7_scan_capture_if #(.NDIG(4)) bus_n ();

  seg7_scan_capture #(.NDIG(4), .STABLE_CYC(4), .SEG_ACTIVE_LOW(1'b0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  seg7_scan_capture #(.NDIG(4), .STABLE_CYC(4), .SEG_ACTIVE_LOW(1'b1)) dut_n (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_n.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Advance n edges, sampling 1 time unit after each edge and counting pulses.
  task automatic run_cycles(input int n);
    upd_cnt   = 0;
    err_cnt   = 0;
    upd_cnt_n = 0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      if (bus.upd) upd_cnt++;
      if (bus.err) err_cnt++;
      if (bus.upd && bus.err) check("upd_err_exclusive", 32'd1, 32'd0);
      if (bus_n.upd) upd_cnt_n++;
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    bus.seg   = 8'h00; bus.an   = 4'b0000;
    bus_n.seg = 8'h00; bus_n.an = 4'b0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_q_bcd",   32'(bus.q_bcd),   32'h0);
    check("rst_q_valid", 32'(bus.q_valid), 32'h0);
    check("rst_upd",     32'(bus.upd),     32'h0);
    check("rst_err",     32'(bus.err),     32'h0);

    // Digit 0 shows 0: capture on the 4th edge only.
    bus.an = 4'b0001; bus.seg = 8'h3F;
    run_cycles(3);
    check("t2_no_early_valid", 32'(bus.q_valid), 32'h0);
    check("t2_no_early_upd",   32'(upd_cnt),     32'd0);
    run_cycles(1);
    check("t2_upd",     32'(bus.upd),     32'h1);
    check("t2_q_bcd",   32'(bus.q_bcd),   32'h0000);
    check("t2_q_valid", 32'(bus.q_valid), 32'h1);
    run_cycles(6);
    check("t2_no_reupd", 32'(upd_cnt), 32'd0);

    // Digit 2: 3-cycle run broken, then a full run of 9.
    bus.an = 4'b0100; bus.seg = 8'h67;
    run_cycles(3);
    check("t3_short_upd", 32'(upd_cnt), 32'd0);
    bus.seg = 8'h00;
    run_cycles(1);
    check("t3_break_err", 32'(err_cnt), 32'd0);
    bus.seg = 8'h67;
    run_cycles(3);
    check("t3_pre_upd", 32'(upd_cnt), 32'd0);
    run_cycles(1);
    check("t3_upd",     32'(bus.upd),     32'h1);
    check("t3_q_bcd",   32'(bus.q_bcd),   32'h0900);
    check("t3_q_valid", 32'(bus.q_valid), 32'h5);

    // Digit 1 holds 5, then an undecodable pattern invalidates it.
    bus.an = 4'b0010; bus.seg = 8'h6D;
    run_cycles(4);
    check("t4_upd5",    32'(upd_cnt),     32'd1);
    check("t4_q_bcd5",  32'(bus.q_bcd),   32'h0950);
    check("t4_valid5",  32'(bus.q_valid), 32'h7);
    bus.seg = 8'h49;
    run_cycles(3);
    check("t4_pre_err", 32'(err_cnt), 32'd0);
    run_cycles(1);
    check("t4_err",     32'(bus.err),     32'h1);
    check("t4_upd0",    32'(bus.upd),     32'h0);
    check("t4_q_valid", 32'(bus.q_valid), 32'h5);
    check("t4_q_bcd",   32'(bus.q_bcd),   32'h0950);
    run_cycles(1);
    check("t4_err_pulse", 32'(bus.err), 32'h0);

    // Non-one-hot selects never capture; dp bit is ignored.
    bus.an = 4'b0011; bus.seg = 8'h06;
    run_cycles(20);
    check("t5_multi_upd", 32'(upd_cnt), 32'd0);
    check("t5_multi_err", 32'(err_cnt), 32'd0);
    bus.an = 4'b0000;
    run_cycles(20);
    check("t5_zero_upd", 32'(upd_cnt + err_cnt), 32'd0);
    check("t5_q_bcd",    32'(bus.q_bcd),   32'h0950);
    check("t5_q_valid",  32'(bus.q_valid), 32'h5);
    bus.an = 4'b1000; bus.seg = 8'hCF;
    run_cycles(4);
    check("t5_dp_upd",   32'(upd_cnt),     32'd1);
    check("t5_dp_q_bcd", 32'(bus.q_bcd),   32'h3950);
    check("t5_dp_valid", 32'(bus.q_valid), 32'hD);

    // Reset mid-run discards the run; capture restarts after release.
    bus.an = 4'b0001; bus.seg = 8'h07;
    run_cycles(2);
    check("t6_pre_rst_upd", 32'(upd_cnt), 32'd0);
    reset = 1'b1;
    #2;
    check("t1_async_q_bcd",   32'(bus.q_bcd),   32'h0);
    check("t1_async_q_valid", 32'(bus.q_valid), 32'h0);
    check("t1_async_upd",     32'(bus.upd),     32'h0);
    check("t1_async_err",     32'(bus.err),     32'h0);
    @(negedge clk);
    reset = 1'b0;
    bus_n.an = 4'b0010; bus_n.seg = 8'hF9;
    run_cycles(3);
    check("t6_pre_upd",   32'(upd_cnt),     32'd0);
    check("t6_pre_valid", 32'(bus.q_valid), 32'h0);
    check("t6n_pre_upd",  32'(upd_cnt_n),   32'd0);
    run_cycles(1);
    check("t6_upd",       32'(bus.upd),       32'h1);
    check("t6_q_bcd",     32'(bus.q_bcd),     32'h0007);
    check("t6_q_valid",   32'(bus.q_valid),   32'h1);
    check("t6n_upd",      32'(bus_n.upd),     32'h1);
    check("t6n_q_bcd",    32'(bus_n.q_bcd),   32'h0010);
    check("t6n_q_valid",  32'(bus_n.q_valid), 32'h2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
